rv32_control_fsm: RTL and testbench

Multi-cycle control unit for the RV32I core. It issues `alu_op` to the ALU and consumes its `result` and `zero_flag`. It holds the instruction register and the sequencing state machine, and it drives every datapath mux select, write strobe and memory request. One instruction runs at a time through FETCH → DECODE → EXECUTE → MEM → WRITEBACK.

---
 rtl/rv32_control_fsm.sv | 244 ++++++++++++++++++++++++
 tb/tb_rv32_control_fsm.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_control_fsm.sv
// Multi-cycle RV32I control unit: instruction register plus the
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer and all datapath controls.
module rv32_control_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  funct3,
  output logic [31:0] imm,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_TRAP
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  state_t      state_reg, state_next;
  logic [31:0] ir_reg;
  // Low from reset until the first edge after release; keeps every output
  // quiet during reset and makes mem_req rise on that first edge.
  logic        run_reg;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        legal;
  logic        fetch_done;
  logic [3:0]  alu_op_dec;
  logic        alu_a_dec, alu_b_dec, br_taken;
  logic [31:0] imm_dec;
  // Only bit 0 of the ALU result matters here (SLT/SLTU outcome).
  logic        unused_alu_bits;

  assign opcode          = ir_reg[6:0];
  assign f3              = ir_reg[14:12];
  assign fetch_done      = run_reg && (state_reg == S_FETCH) && mem_ready;
  assign unused_alu_bits = ^alu_result[31:1];

  // Opcode classification: anything outside the supported set (including
  // SYSTEM, i.e. ECALL/EBREAK) and the two undefined branch funct3 codes trap.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
      OPC_OP_IMM, OPC_OP, OPC_FENCE: legal = 1'b1;
      OPC_BRANCH:                    legal = (f3[2:1] != 2'b01);
      default:                       legal = 1'b0;
    endcase
  end

  // Immediate extraction for each encoding format.
  always_comb begin
    imm_dec = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_dec = {{20{ir_reg[31]}}, ir_reg[31:20]};
      OPC_STORE:
        imm_dec = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
      OPC_BRANCH:
        imm_dec = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_dec = {ir_reg[31:12], 12'h000};
      OPC_JAL:
        imm_dec = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};
      default:
        imm_dec = '0;
    endcase
  end

  // ALU setup per instruction class; held through MEM/WRITEBACK so the
  // datapath sees a stable result when it consumes it.
  always_comb begin
    alu_op_dec = ALU_ADD;
    alu_a_dec  = 1'b0;
    alu_b_dec  = 1'b0;
    br_taken   = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        alu_b_dec = (opcode == OPC_OP_IMM);
        case (f3)
          3'b000:  alu_op_dec = (opcode == OPC_OP && ir_reg[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op_dec = ALU_SLL;
          3'b010:  alu_op_dec = ALU_SLT;
          3'b011:  alu_op_dec = ALU_SLTU;
          3'b100:  alu_op_dec = ALU_XOR;
          3'b101:  alu_op_dec = ir_reg[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op_dec = ALU_OR;
          default: alu_op_dec = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: alu_b_dec = 1'b1;
      OPC_AUIPC: begin
        alu_a_dec = 1'b1;
        alu_b_dec = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3[0] inverts the condition (BNE/BGE/BGEU)
        if (!f3[2]) begin
          alu_op_dec = ALU_SUB;
          br_taken   = zero_flag ^ f3[0];
        end else begin
          alu_op_dec = f3[1] ? ALU_SLTU : ALU_SLT;
          br_taken   = alu_result[0] ^ f3[0];
        end
      end
      default: alu_op_dec = ALU_ADD;
    endcase
  end

  // State, IR and run-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      ir_reg    <= 32'h0000_0013;
      run_reg   <= 1'b0;
    end else begin
      run_reg   <= 1'b1;
      state_reg <= state_next;
      if (fetch_done) ir_reg <= mem_rdata;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (fetch_done) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE:   state_next = S_MEM;
          OPC_BRANCH, OPC_FENCE: state_next = S_FETCH;
          default:               state_next = S_WRITEBACK;
        endcase
      end
      S_MEM:       if (mem_ready) state_next = (opcode == OPC_STORE) ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  // Control outputs decoded from state and IR; all zero until running.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    alu_op       = ALU_ADD;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    pc_write     = 1'b0;
    pc_sel       = 2'd0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;
    if (run_reg) begin
      case (state_reg)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXECUTE: begin
          alu_op    = alu_op_dec;
          alu_a_sel = alu_a_dec;
          alu_b_sel = alu_b_dec;
          if (opcode == OPC_BRANCH) begin
            pc_write = 1'b1;
            pc_sel   = {1'b0, br_taken};
          end else if (opcode == OPC_FENCE) begin
            pc_write = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (opcode == OPC_STORE);
          alu_b_sel    = 1'b1;
          pc_write     = mem_ready && (opcode == OPC_STORE);
        end
        S_WRITEBACK: begin
          alu_op    = alu_op_dec;
          alu_a_sel = alu_a_dec;
          alu_b_sel = alu_b_dec;
          reg_write = (ir_reg[11:7] != 5'd0);
          pc_write  = 1'b1;
          case (opcode)
            OPC_LOAD: wb_sel = 2'd1;
            OPC_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
            OPC_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
            OPC_LUI:  wb_sel = 2'd3;
            default:  wb_sel = 2'd0;
          endcase
        end
        S_TRAP:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign rs1_addr = run_reg ? ir_reg[19:15] : 5'd0;
  assign rs2_addr = run_reg ? ir_reg[24:20] : 5'd0;
  assign rd_addr  = run_reg ? ir_reg[11:7]  : 5'd0;
  assign funct3   = run_reg ? f3            : 3'd0;
  assign imm      = run_reg ? imm_dec       : 32'd0;

endmodule

// File: tb/tb_rv32_control_fsm.sv
// Bench for rv32_control_fsm: a driver plays instruction/data memory and
// pushes the expected per-instruction outcome; a monitor pops and compares
// on every pc_write pulse or trap entry.
module tb_rv32_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] alu_result = '0;
  logic        zero_flag = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write;
  logic [3:0]  alu_op;
  logic        alu_a_sel, alu_b_sel, pc_write, reg_write, halted;
  logic [1:0]  pc_sel, wb_sel;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [2:0]  funct3;
  logic [31:0] imm;

  rv32_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .pc_write(pc_write), .pc_sel(pc_sel), .reg_write(reg_write),
    .wb_sel(wb_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .funct3(funct3), .imm(imm), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         trap;
    int         cycles;     // first FETCH cycle .. pc_write (or trap) cycle
    int         ir_cyc;
    logic [1:0] pc_sel;
    bit         reg_write;
    bit         chk_wb;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    bit         chk_imm;
    logic [31:0] imm;
    bit         chk_alu;
    logic [3:0] alu_op;
    bit         a_sel;
    bit         b_sel;
    bit         chk_hold;
    int         mem_kind;   // 0 none, 1 load, 2 store
    int         mem_cycles;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // R/I-type funct3 -> ALU op (ADD SLL SLT SLTU XOR SRL OR AND)
  localparam logic [3:0] OPTAB [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // Expected behaviour of one instruction from the architectural rules.
  function automatic exp_t model(input logic [31:0] w, input int fw, input int mw,
                                 input logic zf, input logic [31:0] ar);
    exp_t e;
    logic [2:0] f3;
    int base;
    bit taken;
    e = '{default: 0};
    f3 = w[14:12];
    base = 0;
    e.rd = w[11:7];
    e.ir_cyc = fw + 1;
    e.mem_cycles = mw + 1;
    case (w[6:0])
      7'h37: begin base = 4; e.chk_wb = 1; e.wb_sel = 3; e.chk_imm = 1; e.imm = w & 32'hFFFF_F000; end
      7'h17: begin base = 4; e.chk_wb = 1; e.wb_sel = 0; e.chk_imm = 1; e.imm = w & 32'hFFFF_F000;
                   e.chk_alu = 1; e.alu_op = 0; e.a_sel = 1; e.b_sel = 1; end
      7'h6F: begin base = 4; e.chk_wb = 1; e.wb_sel = 2; e.pc_sel = 1; e.chk_imm = 1;
                   e.imm = sext(int'({w[31], w[19:12], w[20], w[30:21]}), 20) << 1; end
      7'h67: begin base = 4; e.chk_wb = 1; e.wb_sel = 2; e.pc_sel = 2; e.chk_hold = 1;
                   e.chk_alu = 1; e.alu_op = 0; e.a_sel = 0; e.b_sel = 1;
                   e.chk_imm = 1; e.imm = sext(int'(w[31:20]), 12); end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) e.trap = 1;
        else begin
          base = 3; e.chk_alu = 1; e.a_sel = 0; e.b_sel = 0;
          case (f3)
            3'd0: begin e.alu_op = 1; taken = zf; end
            3'd1: begin e.alu_op = 1; taken = !zf; end
            3'd4: begin e.alu_op = 8; taken = ar[0]; end
            3'd5: begin e.alu_op = 8; taken = !ar[0]; end
            3'd6: begin e.alu_op = 9; taken = ar[0]; end
            default: begin e.alu_op = 9; taken = !ar[0]; end
          endcase
          e.pc_sel = taken ? 2'd1 : 2'd0;
          e.chk_imm = 1;
          e.imm = sext(int'({w[31], w[7], w[30:25], w[11:8]}), 12) << 1;
        end
      end
      7'h03: begin base = 5; e.chk_wb = 1; e.wb_sel = 1; e.mem_kind = 1;
                   e.chk_alu = 1; e.alu_op = 0; e.b_sel = 1;
                   e.chk_imm = 1; e.imm = sext(int'(w[31:20]), 12); end
      7'h23: begin base = 4; e.mem_kind = 2; e.chk_alu = 1; e.alu_op = 0; e.b_sel = 1;
                   e.chk_imm = 1; e.imm = sext(int'({w[31:25], w[11:7]}), 12); end
      7'h13: begin base = 4; e.chk_wb = 1; e.wb_sel = 0; e.chk_alu = 1; e.b_sel = 1;
                   e.alu_op = (f3 == 3'd5 && w[30]) ? 4'd7 : OPTAB[f3];
                   e.chk_imm = 1; e.imm = sext(int'(w[31:20]), 12); end
      7'h33: begin base = 4; e.chk_wb = 1; e.wb_sel = 0; e.chk_alu = 1; e.b_sel = 0;
                   if (f3 == 3'd0 && w[30]) e.alu_op = 1;
                   else if (f3 == 3'd5 && w[30]) e.alu_op = 7;
                   else e.alu_op = OPTAB[f3]; end
      7'h0F: base = 3;
      default: e.trap = 1;
    endcase
    e.reg_write = e.chk_wb && (w[11:7] != 5'd0);
    if (e.trap) e.cycles = fw + 3;
    else e.cycles = base + fw + ((e.mem_kind != 0) ? mw : 0);
    return e;
  endfunction

  // ---------------- monitor ----------------
  int cyc = 0, ir_cyc = 0, mcyc = 0, trap_cnt = 0, trap_viol = 0, rel = 0;
  bit in_trap = 0, m_we = 0, m_bad = 0;
  logic [3:0] ex_op = 4'hF;
  logic ex_a = 1'b0, ex_b = 1'b0;

  task automatic clear_txn();
    cyc = 0; ir_cyc = 0; mcyc = 0; m_we = 0; m_bad = 0;
    ex_op = 4'hF; ex_a = 1'b0; ex_b = 1'b0;
  endtask

  task automatic compare_txn(input bit got_trap);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_retire", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    $display("txn: trap=%0b cycles=%0d pc_sel=%0d reg_write=%0b wb_sel=%0d rd=%0d imm=%0h",
             got_trap, cyc, pc_sel, reg_write, wb_sel, rd_addr, imm);
    chk("trap", got_trap, e.trap);
    chk("latency", cyc, e.cycles);
    chk("ir_write_cycle", ir_cyc, e.ir_cyc);
    if (!e.trap && !got_trap) begin
      chk("pc_sel", pc_sel, e.pc_sel);
      chk("reg_write", reg_write, e.reg_write);
      if (e.chk_wb) begin
        chk("wb_sel", wb_sel, e.wb_sel);
        chk("rd_addr", rd_addr, e.rd);
      end
      if (e.chk_imm) chk("imm", imm, e.imm);
      if (e.chk_alu) begin
        chk("exec_alu_op", ex_op, e.alu_op);
        chk("exec_alu_a_sel", ex_a, e.a_sel);
        chk("exec_alu_b_sel", ex_b, e.b_sel);
      end
      if (e.chk_hold) chk("wb_alu_hold", {alu_op, alu_a_sel, alu_b_sel}, {4'd0, 1'b0, 1'b1});
      chk("mem_cycles", mcyc, (e.mem_kind != 0) ? e.mem_cycles : 0);
      if (e.mem_kind != 0) begin
        chk("mem_we", m_we, e.mem_kind == 2);
        chk("mem_held_stable", m_bad, 0);
      end
    end
  endtask

  // Sample everything on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl_zero", {mem_req, mem_we, mem_addr_sel, ir_write, alu_op, alu_a_sel, alu_b_sel,
                              pc_write, pc_sel, reg_write, wb_sel, halted}, 0);
      chk("reset_fields_zero", {rs1_addr, rs2_addr, rd_addr, funct3}, 0);
      chk("reset_imm_zero", imm, 0);
      clear_txn();
      in_trap = 0;
      rel = 0;
    end else begin
      if (rel == 0) begin
        chk("mem_req_before_first_edge", mem_req, 0);
        rel = 1;
      end else if (rel == 1) begin
        chk("mem_req_first_edge", {mem_req, mem_addr_sel, mem_we}, 3'b100);
        chk("reset_ir_nop_fields", {rd_addr, rs1_addr, funct3, alu_op}, 0);
        rel = 2;
      end
      if (in_trap) begin
        if (trap_cnt < 20) begin
          if (mem_req || pc_write || reg_write || ir_write || !halted) trap_viol++;
          trap_cnt++;
          if (trap_cnt == 20) chk("trap_quiet_20_cycles", trap_viol, 0);
        end
      end else begin
        if (cyc == 0 && mem_req && !mem_addr_sel) cyc = 1;
        else if (cyc > 0) cyc++;
        if (ir_write) begin
          ir_cyc = cyc;
          chk("ir_write_on_fetch_ready", {mem_req, mem_addr_sel, mem_ready}, 3'b101);
        end
        if (ir_cyc > 0 && cyc == ir_cyc + 2) begin
          ex_op = alu_op; ex_a = alu_a_sel; ex_b = alu_b_sel;
        end
        if (mem_req && mem_addr_sel) begin
          mcyc++;
          if (mcyc == 1) m_we = mem_we;
          else if (mem_we != m_we) m_bad = 1;
          if (alu_op != 4'd0 || alu_a_sel || !alu_b_sel) m_bad = 1;
        end
        if (reg_write && !pc_write) chk("reg_write_without_pc_write", 1, 0);
        if (pc_write || halted) begin
          compare_txn(halted);
          if (halted) begin
            in_trap = 1; trap_cnt = 0; trap_viol = 0;
          end
          clear_txn();
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Wait for a request of the given kind; mem_ready toggles randomly while
  // nothing is requested, which the DUT must ignore.
  task automatic wait_req(input bit sel);
    int n;
    n = 0;
    while (!(mem_req && mem_addr_sel == sel)) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step();
      n++;
      if (n > 60) begin
        $display("FAIL wait_mem_req actual=timeout required=request_sel_%0d", sel);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "no memory request");
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic serve(input int waits, input logic [31:0] data);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      step();
    end
    mem_ready = 1'b1;
    mem_rdata = data;
    step();
    mem_ready = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] w, input int fw, input int mw,
                           input logic zf, input logic [31:0] ar, input int abort_after);
    exp_t e;
    e = model(w, fw, mw, zf, ar);
    wait_req(1'b0);
    zero_flag = zf;
    alu_result = ar;
    exp_q.push_back(e);
    serve(fw, w);
    if (e.trap) begin
      repeat (24) step();
      do_reset();
      return;
    end
    if (e.mem_kind != 0) begin
      wait_req(1'b1);
      if (abort_after >= 0) begin
        repeat (abort_after) step();
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        repeat (2) step();
        rst_n = 1'b1;
        return;
      end
      serve(mw, $urandom);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 3) return w;
    if (r < 5) begin w[6:0] = 7'h73; return w; end
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;
      7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;
      default: w[6:0] = 7'h0F;
    endcase
    return w;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(32'h002081B3, 0, 0, 1'b0, 32'h0, -1);   // ADD x3,x1,x2
    run_instr(32'h4032D293, 1, 0, 1'b0, 32'h0, -1);   // SRAI x5,x5,3
    run_instr(32'h402081B3, 0, 0, 1'b0, 32'h0, -1);   // SUB x3,x1,x2
    run_instr(32'h00208463, 0, 0, 1'b1, 32'h0, -1);   // BEQ taken
    run_instr(32'h0020E463, 0, 0, 1'b0, 32'h0, -1);   // BLTU not taken
    run_instr(32'h0040A283, 0, 3, 1'b0, 32'h0, -1);   // LW, 3 wait cycles
    run_instr(32'h00008067, 0, 0, 1'b0, 32'h0, -1);   // JALR x0,0(x1)
    run_instr(32'h0020A423, 0, 10, 1'b0, 32'h0, 3);   // SW aborted by reset
    run_instr(32'h002081B3, 0, 0, 1'b0, 32'h0, -1);   // ADD after abort
    run_instr(32'h0000000F, 2, 0, 1'b0, 32'h0, -1);   // FENCE
    run_instr(32'h010000EF, 0, 0, 1'b0, 32'h0, -1);   // JAL x1,16
    run_instr(32'h123452B7, 0, 0, 1'b0, 32'h0, -1);   // LUI
    run_instr(32'h00001517, 0, 0, 1'b0, 32'h0, -1);   // AUIPC
    run_instr(32'h0020A423, 1, 0, 1'b0, 32'h0, -1);   // SW zero-wait data
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 32'h0, -1);   // illegal -> trap
    run_instr(32'h00000073, 0, 0, 1'b0, 32'h0, -1);   // ECALL -> trap
    for (int i = 0; i < 300; i++)
      run_instr(rand_instr(), rand_wait(), rand_wait(), 1'($urandom_range(0, 1)), $urandom, -1);
    repeat (10) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
